// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state enum and bundle width for pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
  localparam int STAGE_BUNDLE_W = 219;
endpackage

// File: rtl/skid_data_reg.sv
// skid_data_reg: enabled data register with async active-low clear
module skid_data_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/stage_skid_buffer.sv
// stage_skid_buffer: two-entry skid buffer with fully registered outputs
module stage_skid_buffer
  import pipe_pkg::*;
#(
  parameter int LENGTH = STAGE_BUNDLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic [1:0]        count
);
  skid_state_t state, state_nx;
  logic in_fire, out_fire, main_en, skid_en, main_from_skid;
  logic [LENGTH-1:0] main_q, skid_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= EMPTY;
    else state <= state_nx;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign count     = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // flush only moves state; main/skid keep their stale contents
  always_comb begin
    state_nx = state;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_from_skid = 1'b0;
    if (flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY: if (in_fire) begin
          main_en = 1'b1;
          state_nx = ONE;
        end
        ONE: if (in_fire && out_fire) main_en = 1'b1;
          else if (in_fire) begin
            skid_en = 1'b1;
            state_nx = FULL;
          end else if (out_fire) state_nx = EMPTY;
        FULL: if (out_fire) begin
          main_en = 1'b1;
          main_from_skid = 1'b1;
          state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
  end
  skid_data_reg #(.W(LENGTH)) u_main (
    .clk(clk), .reset(reset), .en(main_en),
    .d(main_from_skid ? skid_q : in_data), .q(main_q)
  );
  skid_data_reg #(.W(LENGTH)) u_skid (
    .clk(clk), .reset(reset), .en(skid_en), .d(in_data), .q(skid_q)
  );
endmodule

// File: tb/tb_stage_skid_buffer.sv
// tb_stage_skid_buffer: directed and random checks against a queue model
module tb_stage_skid_buffer;
  localparam int LENGTH = 219;
  typedef logic [LENGTH-1:0] word_t;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  word_t in_data = '0, out_data;
  logic [1:0] count;
  int total = 0, bad = 0;
  word_t q[$];
  logic fi, fo;
  logic stall_prev = 0;
  word_t data_prev;

  stage_skid_buffer #(.LENGTH(LENGTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input word_t a, input word_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  // model: a bounded FIFO of accepted bundles, cleared by reset or flush
  always @(posedge clk or negedge reset)
    if (!reset) q.delete();
    else if (flush) q.delete();
    else begin
      fi = in_valid && q.size() < 2;
      fo = q.size() > 0 && out_ready;
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(in_data);
    end

  always @(negedge clk) begin
    chk("model_valid", word_t'(out_valid), word_t'(q.size() != 0));
    chk("model_ready", word_t'(in_ready), word_t'(q.size() < 2));
    chk("model_count", word_t'(count), word_t'(q.size()));
    if (q.size() != 0) chk("model_data", out_data, q[0]);
    if (stall_prev && reset) chk("stall_stable", out_data, data_prev);
    stall_prev = reset && out_valid && !out_ready && !flush;
    data_prev = out_data;
  end

  task automatic step(input logic iv, input word_t d, input logic ordy, input logic fl);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [223:0] r;
    #3;
    chk("rst_valid", word_t'(out_valid), word_t'(0));
    chk("rst_ready", word_t'(in_ready), word_t'(1));
    chk("rst_count", word_t'(count), word_t'(0));
    chk("rst_data", out_data, '0);
    #19 reset = 1;
    step(1, 'h1F, 1, 0);
    chk("single_valid", word_t'(out_valid), word_t'(1));
    chk("single_data", out_data, 'h1F);
    step(0, '0, 1, 0);
    chk("single_gone", word_t'(out_valid), word_t'(0));
    for (int i = 1; i <= 8; i++) begin
      step(1, word_t'(i), 1, 0);
      chk("stream_data", out_data, word_t'(i));
      chk("stream_ready", word_t'(in_ready), word_t'(1));
    end
    step(0, '0, 1, 0);
    step(1, 'hA, 0, 0);
    step(1, 'hB, 0, 0);
    chk("full_count", word_t'(count), word_t'(2));
    chk("full_ready", word_t'(in_ready), word_t'(0));
    chk("full_data", out_data, 'hA);
    step(1, 'hC, 0, 0);
    chk("full_hold", out_data, 'hA);
    step(1, 'hC, 1, 0);
    chk("drain_b", out_data, 'hB);
    step(1, 'hC, 1, 0);
    chk("drain_c", out_data, 'hC);
    step(0, '0, 1, 0);
    chk("drain_empty", word_t'(out_valid), word_t'(0));
    step(1, 'h11, 0, 0);
    step(1, 'h22, 0, 0);
    step(1, 'h55, 1, 1);
    chk("flush_count", word_t'(count), word_t'(0));
    chk("flush_valid", word_t'(out_valid), word_t'(0));
    repeat (3) begin
      step(0, '0, 1, 0);
      chk("flush_no55", word_t'(out_valid), word_t'(0));
    end
    step(1, 'h77, 0, 0);
    chk("one_valid", word_t'(out_valid), word_t'(1));
    #2 reset = 0;
    #1;
    chk("async_valid", word_t'(out_valid), word_t'(0));
    chk("async_data", out_data, '0);
    chk("async_count", word_t'(count), word_t'(0));
    @(negedge clk);
    #1 reset = 1;
    step(1, 'h99, 1, 0);
    chk("release_accept", out_data, 'h99);
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 3) != 0), r[LENGTH-1:0], 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    step(0, '0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_skid_buffer.md
STAGE_SKID_BUFFER -- requirements
Module: stage_skid_buffer

Interface
REQ-001 The block SHALL have parameter LENGTH, default 219, giving the bit width of one pipeline-stage bundle.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port flush, input, 1, synchronous discard of all held bundles.
REQ-005 The block SHALL have port in_valid, input, 1, upstream bundle present.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a bundle this cycle.
REQ-007 The block SHALL have port in_data, input, LENGTH, upstream bundle.
REQ-008 The block SHALL have port out_valid, output, 1, bundle presented to the downstream stage.
REQ-009 The block SHALL have port out_ready, input, 1, downstream consumes the bundle this cycle.
REQ-010 The block SHALL have port out_data, output, LENGTH, presented bundle.
REQ-011 The block SHALL have port count, output, 2, number of held bundles (0..2).

Function
REQ-012 The block SHALL define in-fire = in_valid & in_ready and out-fire = out_valid & out_ready.
REQ-013 The block SHALL implement states EMPTY, ONE and FULL, holding 0, 1 and 2 bundles in registers main and skid.
REQ-014 The block SHALL drive out_valid = (state != EMPTY), out_data = main, in_ready = (state != FULL), and count = 0/1/2 for EMPTY/ONE/FULL; all four are functions of registered state only, with no combinational in-to-out path.
REQ-015 In EMPTY on in-fire, the block SHALL load main <= in_data and go to ONE.
REQ-016 In ONE on in-fire & out-fire, the block SHALL load main <= in_data and stay in ONE.
REQ-017 In ONE on in-fire only, the block SHALL load skid <= in_data and go to FULL.
REQ-018 In ONE on out-fire only, the block SHALL go to EMPTY.
REQ-019 In ONE with neither fire, the block SHALL hold all state.
REQ-020 In FULL on out-fire, the block SHALL load main <= skid and go to ONE; in_valid is ignored in FULL because in_ready = 0.
REQ-021 Latency SHALL be 1 cycle: a bundle accepted at edge N appears on out_data after edge N (when the block was empty or draining).
REQ-022 Sustained throughput SHALL be 1 bundle/cycle while out_ready = 1.
REQ-023 Bundles SHALL leave in acceptance order, never duplicated or dropped, except on flush.
REQ-024 out_data and out_valid SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025 flush SHALL take priority over all other events: next state EMPTY regardless of in_valid/out_ready; an in_data offered in the flush cycle is discarded.
REQ-026 main and skid contents SHALL be left unchanged by flush (don't-care while EMPTY).

Reset
REQ-027 While reset = 0, the block SHALL immediately force state EMPTY, main = 0 and skid = 0, giving out_valid = 0, out_data = 0, in_ready = 1 and count = 0, independent of clk.
REQ-028 On reset release, the block SHALL accept in-fire at the first rising edge with reset = 1.
REQ-029 Reset asserted mid-transfer SHALL drop all held bundles; no partial update of main or skid is visible afterward.

Structure
REQ-030 Package pipe_pkg SHALL hold the state enum (skid_state_t: EMPTY, ONE, FULL) and the constant STAGE_BUNDLE_W = 219, used as the LENGTH default.
REQ-031 Sub-module skid_data_reg SHALL implement one LENGTH-wide enabled register with async active-low clear, instantiated twice (main, skid).
REQ-032 The state machine and the main/skid load-select mux SHALL live in stage_skid_buffer.

Verification
REQ-033 After reset, in_valid = 1 with data 0x1F for 1 cycle and out_ready = 1: out_valid = 1 with out_data = 0x1F for exactly 1 cycle, then out_valid = 0.
REQ-034 Stream values 1..8 on consecutive cycles with out_ready = 1: values 1..8 appear on consecutive cycles, and in_ready stays 1 throughout.
REQ-035 out_ready = 0 with values A, B, C offered: A and B are accepted, count = 2, in_ready = 0, and out_data holds A; after out_ready = 1, the block emits A, B, C in order.
REQ-036 In FULL, assert flush with in_valid = 1 (data 0x55): next cycle count = 0, out_valid = 0, and 0x55 is never emitted.
REQ-037 Drop reset to 0 between clock edges while in ONE: out_valid = 0 and out_data = 0 immediately, before the next edge.
REQ-038 Randomised in_valid/out_ready for 10k cycles against a queue model: no order violation or loss, and out_data is stable under stall.
